// File: rtl/dmem_arbiter24.sv
// dmem_arbiter24: round-robin arbiter sharing the single-port 24-bit data RAM
// between the CPU load/store path (requester 0) and the host/DMA loader
// (requester 1). Requester 1 may take a bounded atomic lock.
// Optional feature macro: DMEM_WPROT_EN. When defined, requester-0 writes
// below PROT_LIMIT are granted but suppressed at the RAM, and wprot_err pulses.
module dmem_arbiter24 #(
  parameter int unsigned     AW         = 14,
  parameter int unsigned     DW         = 24,
  parameter int unsigned     LOCK_MAX   = 8,
  parameter logic [AW-1:0]   PROT_LIMIT = AW'(14'h3000)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  input  logic          lock1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          wprot_err
);

`ifdef DMEM_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  localparam int unsigned CW = $clog2(LOCK_MAX + 1) + 1;

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_LOCK = 2'd1,
    S_COOL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_winner_q, last_winner_d;  // 1 = requester 1 won last
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          wprot_err_q, wprot_err_d;
  logic          gnt0_c, gnt1_c;
  logic          prot_hit;

  // Arbitration FSM: grants are combinational, forced low while in reset.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    lock_cnt_d    = lock_cnt_q;
    gnt0_c        = 1'b0;
    gnt1_c        = 1'b0;
    case (state_q)
      S_ARB: begin
        gnt0_c     = req0 & (~req1 | last_winner_q);
        gnt1_c     = req1 & (~req0 | ~last_winner_q);
        lock_cnt_d = '0;
        if (gnt1_c && lock1) begin
          state_d    = S_LOCK;
          lock_cnt_d = CW'(1);
        end
      end
      S_LOCK: begin
        gnt1_c     = req1;
        lock_cnt_d = lock_cnt_q + CW'(1);
        // Lock release wins over the cool-down when both coincide.
        if (!lock1) begin
          state_d    = S_ARB;
          lock_cnt_d = '0;
        end else if (lock_cnt_d >= CW'(LOCK_MAX)) begin
          state_d    = S_COOL;
          lock_cnt_d = '0;
        end
      end
      S_COOL: begin
        gnt0_c     = req0;
        gnt1_c     = req1 & ~req0;
        state_d    = S_ARB;
        lock_cnt_d = '0;
      end
      default: begin
        state_d    = S_ARB;
        lock_cnt_d = '0;
      end
    endcase
    if (!rst_n) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end
    if (gnt0_c) begin
      last_winner_d = 1'b0;
    end else if (gnt1_c) begin
      last_winner_d = 1'b1;
    end else if (state_q == S_COOL) begin
      last_winner_d = 1'b1;
    end
  end

  // RAM port mux from the winner; protected CPU writes are dropped here.
  always_comb begin
    prot_hit    = WPROT_EN & gnt0_c & we0 & (addr0 < PROT_LIMIT);
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    rvalid0_d   = gnt0_c & ~we0;
    rvalid1_d   = gnt1_c & ~we1;
    wprot_err_d = prot_hit;
    if (gnt0_c) begin
      mem_we    = we0 & ~prot_hit;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1_c) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // State and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_ARB;
      last_winner_q <= 1'b1;
      lock_cnt_q    <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      wprot_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      lock_cnt_q    <= lock_cnt_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      wprot_err_q   <= wprot_err_d;
    end
  end

  assign gnt0      = gnt0_c;
  assign gnt1      = gnt1_c;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rvalid0_q ? mem_rdata : '0;
  assign rdata1    = rvalid1_q ? mem_rdata : '0;
  assign wprot_err = wprot_err_q;

endmodule

// File: doc/dmem_arbiter24.md
Name: dmem_arbiter24

Overview:
Shares the single-port, word-addressed 24-bit data RAM between two requesters. Requester 0 is the multi-cycle CPU load/store path. Requester 1 is a host/DMA loader that fills and reads back the X/W/b data regions. Arbitration is round-robin, and requester 1 can additionally take an atomic lock for bounded bursts. The block sits between both masters and the RAM, replacing the CPU's direct connection to the RAM port.

Parameters:
AW, 14, data-memory word-address width
DW, 24, data word width
LOCK_MAX, 8, maximum consecutive cycles requester 1 may hold a lock (≥1)
PROT_LIMIT, 14'h3000, lowest address requester 0 may write (used only with DMEM_WPROT_EN)

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req0  in  1  requester 0 (CPU) access request
we0  in  1  requester 0 write enable (1 = write, 0 = read)
addr0  in  AW  requester 0 word address
wdata0  in  DW  requester 0 write data
gnt0  out  1  requester 0 granted this cycle
rvalid0  out  1  requester 0 read data valid
rdata0  out  DW  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  (same as requester 0)  requester 1 (host/DMA)
lock1  in  1  requester 1 requests exclusive ownership of the port
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM synchronous read data, valid 1 cycle after address
wprot_err  out  1  write-protect violation pulse (tied 0 when DMEM_WPROT_EN is undefined)

Behaviour:
- Reset (rst_n=0, asynchronous): state=S_ARB, last_winner=1, lock_cnt=0, rvalid0=rvalid1=0, wprot_err=0. gnt0 and gnt1 are forced 0 while reset is asserted. rdata0 and rdata1 read 0.
- Grant timing:
  - gntN is combinational from reqN, state and last_winner.
  - A granted access is presented to the RAM in the same cycle: mem_addr, mem_we and mem_wdata are muxed from the winner.
  - With no grant: mem_we=0, mem_addr and mem_wdata hold 0.
  - Each grant is exactly one word access. A requester keeps reqN high until it sees gntN. Its address, data and write-enable must stay stable while reqN is high and ungranted.
- Read latency: a granted read sets rvalidN on the next rising edge for exactly 1 cycle. rdataN = mem_rdata while rvalidN=1, otherwise 0. Writes produce no rvalid. Back-to-back reads give one rvalid per grant.
- States:
  - S_ARB:
    - Round-robin: with only one requester asserting, it wins. With both asserting, the one not equal to last_winner wins. last_winner updates on every grant.
    - If req1 and lock1 are both high and requester 1 wins, go to S_LOCK with lock_cnt=1.
  - S_LOCK:
    - gnt0=0. gnt1=req1.
    - lock_cnt increments each cycle.
    - Exit to S_ARB when lock1=0.
    - Exit to S_COOL when lock_cnt==LOCK_MAX while lock1 is still high.
  - S_COOL:
    - Exactly 1 cycle. Requester 0 has strict priority: gnt0=req0, gnt1=req1 & ~req0. lock1 is ignored.
    - Then go to S_ARB with last_winner set to the cycle's winner, or 1 if there was no grant.
- Simultaneous events:
  - lock1 rising in S_ARB while requester 0 wins: no lock is taken that cycle, and requester 1 retries.
  - lock1 falling in the same cycle that lock_cnt reaches LOCK_MAX: go to S_ARB, not S_COOL.
- Reset mid-operation: a pending rvalid is cancelled immediately and any pending grant drops. No RAM write occurs while rst_n=0.

Optional Feature:
DMEM_WPROT_EN:
- Defined: a requester-0 write with addr0 < PROT_LIMIT is granted normally, but mem_we is held 0 for that cycle. wprot_err pulses high for 1 cycle on the following edge.
- Requester 1 writes are never filtered.
- Undefined: no filtering, and wprot_err is constant 0.

Test Plan:
- Reset, then req0 and req1 asserted together and held for 4 cycles → gnt0 in cycle 1, gnt1 in cycle 2, alternating 0,1,0,1.
- Preload RAM[0x0010]=0x123456, requester 0 reads 0x0010 → gnt0 in the same cycle; rvalid0=1 and rdata0=0x123456 the next cycle; rvalid0=0 after that.
- LOCK_MAX=4, lock1 and req1 held high, req0 high throughout → gnt1 for 4 consecutive cycles, then gnt0 in the S_COOL cycle, then round-robin resumes.
- lock1 dropped after 2 locked cycles, req0 high → gnt0 on the next cycle via S_ARB, with no S_COOL cycle.
- DMEM_WPROT_EN: requester 0 writes 0xABCDEF to 0x2FFF → gnt0=1, mem_we=0, wprot_err pulses, RAM unchanged. Requester 0 writes to 0x3000 → mem_we=1, RAM updated, no error.
- Requester 0 read granted, then rst_n pulled low mid-cycle before rvalid0 → rvalid0, gnt0 and gnt1 drop to 0 immediately. After release, the first simultaneous request goes to requester 0.
